// File: rtl/delta_monitor.sv
// Checks that a sampled counter stream advances by STEP per valid sample, locking
// after LOCK_N consecutive matches and counting slips that occur while locked.
module delta_monitor #(
    parameter logic [7:0]  STEP   = 8'h01,
    parameter int unsigned LOCK_N = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] __in0,
    input  logic       __in1,
    input  logic       __in2,
    output logic [7:0] __out0,
    output logic       __out1,
    output logic       __out2,
    output logic [7:0] __out3
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        PRIMED = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_N);

    state_e     state_q, state_d;
    logic [7:0] prev_q, prev_d;
    logic [3:0] run_q, run_d;
    logic [7:0] delta_q, delta_d;
    logic       locked_q, locked_d;
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;

    logic [7:0] delta;
    logic       match;
    logic [3:0] run_inc;

    // Modulo-256 subtraction makes FF -> 00 a delta of 1 with no special case.
    assign delta   = __in0 - prev_q;
    assign match   = (delta == STEP);
    assign run_inc = run_q + 4'd1;

    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all of them sample pre-edge values together.
        if (rst) begin
            state_q  <= EMPTY;
            prev_q   <= 8'h00;
            run_q    <= 4'd0;
            delta_q  <= 8'h00;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            run_q    <= run_d;
            delta_q  <= delta_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every target and no latch is inferred.
        state_d = state_q;
        prev_d  = prev_q;
        run_d   = run_q;
        if (__in1) begin
            prev_d = __in0;
            case (state_q)
                EMPTY: begin
                    run_d   = 4'd0;
                    state_d = PRIMED;
                end
                PRIMED: begin
                    if (match) begin
                        run_d = run_inc;
                        if (run_inc == LOCK_RUN) state_d = LOCKED;
                    end else begin
                        run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    if (!match) begin
                        run_d   = 4'd0;
                        state_d = PRIMED;
                    end
                end
                default: begin
                    run_d   = 4'd0;
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_comb begin
        delta_d  = delta_q;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        locked_d = (state_d == LOCKED);
        if (__in1) begin
            delta_d = (state_q == EMPTY) ? 8'h00 : delta;
            err_d   = (state_q == LOCKED) && !match;
        end
        // A clear coinciding with an error leaves that one error counted.
        if (__in2)
            cnt_d = {7'd0, err_d};
        else if (err_d && (cnt_q != 8'hFF))
            cnt_d = cnt_q + 8'd1;
    end

    assign __out0 = delta_q;
    assign __out1 = locked_q;
    assign __out2 = err_q;
    assign __out3 = cnt_q;

endmodule

// File: tb/tb_delta_monitor.sv
// Directed bench for delta_monitor: a vector table for the main scenarios plus
// hand-written sequences for saturation/clear and the LOCK_N=1 variant.
module tb_delta_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in0;
    logic       in1;
    logic       in2;
    logic [7:0] out0, a_out0;
    logic       out1, a_out1;
    logic       out2, a_out2;
    logic [7:0] out3, a_out3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    delta_monitor dut (
        .clk(clk), .rst(rst), .__in0(in0), .__in1(in1), .__in2(in2),
        .__out0(out0), .__out1(out1), .__out2(out2), .__out3(out3)
    );

    delta_monitor #(.STEP(8'h01), .LOCK_N(1)) dut_n1 (
        .clk(clk), .rst(rst), .__in0(in0), .__in1(in1), .__in2(in2),
        .__out0(a_out0), .__out1(a_out1), .__out2(a_out2), .__out3(a_out3)
    );

    typedef struct {
        string      name;
        logic       r;
        logic       v;
        logic       c;
        logic [7:0] s;
        logic [7:0] d;
        logic       l;
        logic       e;
        logic [7:0] n;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic v, input logic c,
                       input logic [7:0] s, input logic [7:0] d, input logic l,
                       input logic e, input logic [7:0] n);
        vec_t t;
        t.name = name; t.r = r; t.v = v; t.c = c; t.s = s;
        t.d = d; t.l = l; t.e = e; t.n = n;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the edge they take effect on.
    task automatic apply(input logic r, input logic v, input logic c, input logic [7:0] s);
        rst = r; in1 = v; in2 = c; in0 = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [7:0] d, input logic l,
                             input logic e, input logic [7:0] n);
        check({name, ".delta"},  out0, d);
        check({name, ".locked"}, {7'd0, out1}, {7'd0, l});
        check({name, ".err"},    {7'd0, out2}, {7'd0, e});
        check({name, ".count"},  out3, n);
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] exp_n;

        rst = 1'b1; in1 = 1'b0; in2 = 1'b0; in0 = 8'h00;

        //   name       r  v  c  sample  delta lock err count
        add("reset0",   1, 0, 0, 8'd0,   8'd0, 0, 0, 8'd0);
        add("lock10",   0, 1, 0, 8'd10,  8'd0, 0, 0, 8'd0);
        add("lock11",   0, 1, 0, 8'd11,  8'd1, 0, 0, 8'd0);
        add("lock12",   0, 1, 0, 8'd12,  8'd1, 0, 0, 8'd0);
        add("lock13",   0, 1, 0, 8'd13,  8'd1, 0, 0, 8'd0);
        add("lock14",   0, 1, 0, 8'd14,  8'd1, 1, 0, 8'd0);
        add("idle",     0, 0, 0, 8'd99,  8'd1, 1, 0, 8'd0);
        add("rst_w",    1, 0, 0, 8'd0,   8'd0, 0, 0, 8'd0);
        add("wF9",      0, 1, 0, 8'hF9,  8'd0, 0, 0, 8'd0);
        add("wFA",      0, 1, 0, 8'hFA,  8'd1, 0, 0, 8'd0);
        add("wFB",      0, 1, 0, 8'hFB,  8'd1, 0, 0, 8'd0);
        add("wFC",      0, 1, 0, 8'hFC,  8'd1, 0, 0, 8'd0);
        add("wFD",      0, 1, 0, 8'hFD,  8'd1, 1, 0, 8'd0);
        add("wFE",      0, 1, 0, 8'hFE,  8'd1, 1, 0, 8'd0);
        add("wFF",      0, 1, 0, 8'hFF,  8'd1, 1, 0, 8'd0);
        add("w00",      0, 1, 0, 8'h00,  8'd1, 1, 0, 8'd0);
        add("w01",      0, 1, 0, 8'h01,  8'd1, 1, 0, 8'd0);
        add("rst_e",    1, 0, 0, 8'd0,   8'd0, 0, 0, 8'd0);
        add("e16",      0, 1, 0, 8'd16,  8'd0, 0, 0, 8'd0);
        add("e17",      0, 1, 0, 8'd17,  8'd1, 0, 0, 8'd0);
        add("e18",      0, 1, 0, 8'd18,  8'd1, 0, 0, 8'd0);
        add("e19",      0, 1, 0, 8'd19,  8'd1, 0, 0, 8'd0);
        add("e20",      0, 1, 0, 8'd20,  8'd1, 1, 0, 8'd0);
        add("e25",      0, 1, 0, 8'd25,  8'd5, 0, 1, 8'd1);
        add("e_after",  0, 0, 0, 8'd0,   8'd5, 0, 0, 8'd1);
        add("e26",      0, 1, 0, 8'd26,  8'd1, 0, 0, 8'd1);
        add("e27",      0, 1, 0, 8'd27,  8'd1, 0, 0, 8'd1);
        add("e28",      0, 1, 0, 8'd28,  8'd1, 0, 0, 8'd1);
        add("e29",      0, 1, 0, 8'd29,  8'd1, 1, 0, 8'd1);
        add("rst_g",    1, 0, 0, 8'd0,   8'd0, 0, 0, 8'd0);
        add("g30",      0, 1, 0, 8'd30,  8'd0, 0, 0, 8'd0);
        add("gap1",     0, 0, 0, 8'd77,  8'd0, 0, 0, 8'd0);
        add("gap2",     0, 0, 0, 8'd200, 8'd0, 0, 0, 8'd0);
        add("g31",      0, 1, 0, 8'd31,  8'd1, 0, 0, 8'd0);
        add("gap3",     0, 0, 0, 8'd5,   8'd1, 0, 0, 8'd0);
        add("g40",      0, 1, 0, 8'd40,  8'd9, 0, 0, 8'd0);
        add("m16",      0, 1, 0, 8'd41,  8'd1, 0, 0, 8'd0);
        add("m17",      0, 1, 0, 8'd42,  8'd1, 0, 0, 8'd0);
        add("m18",      0, 1, 0, 8'd43,  8'd1, 0, 0, 8'd0);
        add("m19",      0, 1, 0, 8'd44,  8'd1, 1, 0, 8'd0);
        add("m_err",    0, 1, 0, 8'd50,  8'd6, 0, 1, 8'd1);
        add("rst_mid",  1, 1, 1, 8'd99,  8'd0, 0, 0, 8'd0);
        add("r50",      0, 1, 0, 8'd50,  8'd0, 0, 0, 8'd0);
        add("r51",      0, 1, 0, 8'd51,  8'd1, 0, 0, 8'd0);

        foreach (vecs[i]) begin
            apply(vecs[i].r, vecs[i].v, vecs[i].c, vecs[i].s);
            check_all(vecs[i].name, vecs[i].d, vecs[i].l, vecs[i].e, vecs[i].n);
        end

        // LOCK_N=1: locks on the first matching delta after priming.
        apply(1, 0, 0, 8'd0);
        apply(0, 1, 0, 8'd10);
        check("n1_prime.locked", {7'd0, a_out1}, 8'd0);
        apply(0, 1, 0, 8'd11);
        check("n1_lock.locked", {7'd0, a_out1}, 8'd1);
        check("n1_lock.delta", a_out0, 8'd1);
        check("n1_main.locked", {7'd0, out1}, 8'd0);
        apply(0, 1, 0, 8'd13);
        check("n1_err.err", {7'd0, a_out2}, 8'd1);
        check("n1_err.count", a_out3, 8'd1);

        // Saturation: 260 errors, each followed by a four-sample relock.
        apply(1, 0, 0, 8'd0);
        s = 8'd0;
        apply(0, 1, 0, s);
        for (int k = 0; k < 4; k++) begin
            s = s + 8'd1;
            apply(0, 1, 0, s);
        end
        check("sat_lock.locked", {7'd0, out1}, 8'd1);
        for (int i = 0; i < 260; i++) begin
            s = s + 8'd2;
            apply(0, 1, 0, s);
            exp_n = (i >= 254) ? 8'hFF : 8'(i + 1);
            if (i == 0 || i == 253 || i == 254 || i == 259) begin
                check($sformatf("sat%0d.err", i), {7'd0, out2}, 8'd1);
                check($sformatf("sat%0d.count", i), out3, exp_n);
            end
            for (int k = 0; k < 4; k++) begin
                s = s + 8'd1;
                apply(0, 1, 0, s);
            end
        end
        check_all("sat_end", 8'd1, 1, 0, 8'hFF);

        // Clear coinciding with an error leaves a count of one.
        s = s + 8'd2;
        apply(0, 1, 1, s);
        check_all("clr_err", 8'd2, 0, 1, 8'd1);
        for (int k = 0; k < 4; k++) begin
            s = s + 8'd1;
            apply(0, 1, 0, s);
        end
        check_all("relock", 8'd1, 1, 0, 8'd1);
        apply(0, 0, 1, 8'd0);
        check_all("clr_only", 8'd1, 1, 0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
